// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, opcodes, mux selects.
// Also holds the per-state Moore control table used to load the registered outputs.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_ERROR   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_REGB    = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // FETCH's ir_write/pc_write depend on mem_ready and are added at the top level.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCS_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SL2;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_ADDI_WB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REGB;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JUMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of one memory access; expired_o flags the last allowed stall cycle.
// Combinational expiry, counter cleared by the sequencer on every state change.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic wait_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (wait_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = wait_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: Moore controls registered from next state, FETCH load
// strobes qualified by mem_ready; stalls while memory is not ready, halts in ERROR on timeout.
module multicycle_ctrl_fsm
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic             mem_error,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q;
  logic             illegal_q, mem_error_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire, set_illegal;
  logic             in_wait, timeout, fetch_done;

  // zero is consumed by the datapath together with pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_d != state_q),
    .wait_i    (in_wait && !mem_ready),
    .expired_o (timeout)
  );

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_ERROR;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            set_illegal = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_ERROR;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_EXEC:    state_d = S_RWB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEMWB, S_RWB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      mem_error_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
      if (retire)              retired_q   <= retired_q + CNT_W'(1);
      if (set_illegal)         illegal_q   <= 1'b1;
      if (state_d == S_ERROR)  mem_error_q <= 1'b1;
    end
  end

  assign fetch_done = (state_q == S_FETCH) && mem_ready;

  assign pc_write      = ctrl_q.pc_write | fetch_done;
  assign ir_write      = ctrl_q.ir_write | fetch_done;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  assign illegal_op    = illegal_q;
  assign mem_error     = mem_error_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench: each instruction expands into its phase list; every cycle's controls,
// flags and retire count are compared against a table-driven model of the sequencer.
module tb_multicycle_ctrl_fsm;

  localparam int TO = 16;
  localparam int CW = 4;

  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_MEMADR = 3, PH_MEMRD = 4;
  localparam int PH_MEMWB = 5, PH_MEMWR = 6, PH_EXEC = 7, PH_RWB = 8, PH_ADDI_EX = 9;
  localparam int PH_ADDI_WB = 10, PH_BRANCH = 11, PH_JUMP = 12, PH_ERROR = 13;

  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_J = 6'b000010, T_ADDI = 6'b001000;

  typedef struct packed {
    logic       pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, aop, psrc;
  } tb_ctrl_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          zero, mem_ready;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic          reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic          illegal_op, mem_error;
  logic [CW-1:0] retired;

  tb_ctrl_t      act;
  logic          exp_ill, exp_err;
  logic [CW-1:0] exp_ret;
  int            n_cmp = 0;
  int            n_bad = 0;

  multicycle_ctrl_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .mem_error(mem_error), .retired(retired)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  function automatic tb_ctrl_t expect_ctrl(input int ph, input logic mr);
    tb_ctrl_t c;
    c = '0;
    case (ph)
      PH_FETCH:               begin c.mrd = 1'b1; c.asb = 2'd1; c.pw = mr; c.irw = mr; end
      PH_DECODE:              c.asb = 2'd3;
      PH_MEMADR, PH_ADDI_EX:  begin c.asa = 1'b1; c.asb = 2'd2; end
      PH_MEMRD:               begin c.mrd = 1'b1; c.iod = 1'b1; end
      PH_MEMWB:               begin c.rw = 1'b1; c.m2r = 1'b1; end
      PH_MEMWR:               begin c.mwr = 1'b1; c.iod = 1'b1; end
      PH_EXEC:                begin c.asa = 1'b1; c.aop = 2'd2; end
      PH_RWB:                 begin c.rw = 1'b1; c.rdst = 1'b1; end
      PH_ADDI_WB:             c.rw = 1'b1;
      PH_BRANCH:              begin c.asa = 1'b1; c.aop = 2'd1; c.pwc = 1'b1; c.psrc = 2'd1; end
      PH_JUMP:                begin c.pw = 1'b1; c.psrc = 2'd2; end
      default:                c = '0;
    endcase
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // One clock of stimulus: drive inputs, compare at the falling edge, advance past the rise.
  task automatic step(input logic mr, input logic z, input int ph, input string tag);
    mem_ready = mr;
    zero      = z;
    @(negedge clk);
    check({tag, " ctrl"}, 32'(act), 32'(expect_ctrl(ph, mr)));
    check({tag, " flags"}, 32'({illegal_op, mem_error}), 32'({exp_ill, exp_err}));
    check({tag, " retired"}, 32'(retired), 32'(exp_ret));
    @(posedge clk);
    #1;
  endtask

  task automatic mem_phase(input int delay, input int ph, input string tag, output bit to);
    for (int k = 0; k < delay && k < TO; k++) step(1'b0, 1'b0, ph, tag);
    if (delay >= TO) begin
      to      = 1'b1;
      exp_err = 1'b1;
    end else begin
      step(1'b1, 1'b0, ph, tag);
      to = 1'b0;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fdly, input int mdly,
                           input logic z, output bit to);
    opcode = op;
    mem_phase(fdly, PH_FETCH, "fetch", to);
    if (to) return;
    step(1'b0, 1'b0, PH_DECODE, "decode");
    case (op)
      T_R:    begin step(1'b0, 1'b0, PH_EXEC, "exec"); step(1'b0, 1'b0, PH_RWB, "rwb"); exp_ret++; end
      T_ADDI: begin step(1'b0, 1'b0, PH_ADDI_EX, "addi_ex"); step(1'b0, 1'b0, PH_ADDI_WB, "addi_wb"); exp_ret++; end
      T_BEQ:  begin step(1'b0, z, PH_BRANCH, "branch"); exp_ret++; end
      T_J:    begin step(1'b0, 1'b0, PH_JUMP, "jump"); exp_ret++; end
      T_LW: begin
        step(1'b0, 1'b0, PH_MEMADR, "memadr");
        mem_phase(mdly, PH_MEMRD, "memrd", to);
        if (to) return;
        step(1'b0, 1'b0, PH_MEMWB, "memwb");
        exp_ret++;
      end
      T_SW: begin
        step(1'b0, 1'b0, PH_MEMADR, "memadr");
        mem_phase(mdly, PH_MEMWR, "memwr", to);
        if (!to) exp_ret++;
      end
      default: exp_ill = 1'b1;
    endcase
  endtask

  initial begin
    bit to;
    rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    exp_ill = 1'b0; exp_err = 1'b0; exp_ret = '0;
    #3;
    check("reset ctrl", 32'(act), 32'd0);
    check("reset retired", 32'(retired), 32'd0);
    check("reset flags", 32'({illegal_op, mem_error}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, PH_IDLE, "idle");

    run_instr(T_LW, 0, 0, 1'b0, to);
    check("lw retired", 32'(retired), 32'd1);
    run_instr(T_R, 3, 0, 1'b0, to);
    run_instr(T_BEQ, 0, 0, 1'b1, to);
    run_instr(T_BEQ, 1, 0, 1'b0, to);
    run_instr(T_ADDI, 0, 0, 1'b0, to);
    run_instr(6'b111111, 0, 0, 1'b0, to);
    check("illegal flag", 32'(illegal_op), 32'd1);
    check("illegal retired", 32'(retired), 32'd5);
    run_instr(T_SW, 2, TO - 1, 1'b0, to);
    check("sw limit-1 retired", 32'(retired), 32'd6);
    run_instr(T_LW, 0, 4, 1'b0, to);

    // Async reset while a store is stalled must drop the write request immediately.
    opcode = T_SW;
    mem_phase(0, PH_FETCH, "fetch", to);
    step(1'b0, 1'b0, PH_DECODE, "decode");
    step(1'b0, 1'b0, PH_MEMADR, "memadr");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, PH_MEMWR, "memwr");
    rst_n = 1'b0;
    #1;
    check("midreset mem_write", 32'(mem_write), 32'd0);
    check("midreset ctrl", 32'(act), 32'd0);
    check("midreset retired", 32'(retired), 32'd0);
    check("midreset illegal", 32'(illegal_op), 32'd0);
    exp_ill = 1'b0; exp_err = 1'b0; exp_ret = '0;
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, PH_IDLE, "idle2");

    for (int j = 0; j < 16; j++) begin
      run_instr(T_J, 0, 0, 1'b0, to);
      if (j == 14) check("jump15 retired", 32'(retired), 32'd15);
    end
    check("jump wrap retired", 32'(retired), 32'd0);

    run_instr(T_SW, 0, TO, 1'b0, to);
    check("timeout seen", 32'(to), 32'd1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, PH_ERROR, "error");
    check("error mem_error", 32'(mem_error), 32'd1);
    check("error mem_write", 32'(mem_write), 32'd0);
    check("error retired", 32'(retired), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
